// File: rtl/alu_pkg.sv
// Shared encodings for the ALU result stage: result-select codes and skid-buffer states.
package alu_pkg;

    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_ADD = 2'b10;
    localparam logic [1:0] SEL_SUB = 2'b11;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b01,
        FULL  = 2'b10
    } buf_state_e;

endpackage

// File: rtl/alu_result_mux.sv
// Combinational 4:1 selection of the ALU unit results.
module alu_result_mux
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] res_and,
    input  logic [WIDTH-1:0] res_or,
    input  logic [WIDTH-1:0] res_add,
    input  logic [WIDTH-1:0] res_sub,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        // NOTE: y is assigned before the case so no path can leave it unassigned and infer a latch.
        y = res_and;
        case (sel)
            SEL_OR:  y = res_or;
            SEL_ADD: y = res_add;
            SEL_SUB: y = res_sub;
            default: y = res_and;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage with a 2-entry skid buffer, valid/ready handshakes and delivery counter.
// Optional macro ALU_RESULT_FLAGS_EN builds zero/negative flags stored alongside each entry.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] res_and,
    input  logic [WIDTH-1:0] res_or,
    input  logic [WIDTH-1:0] res_add,
    input  logic [WIDTH-1:0] res_sub,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_cnt
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] mux_y;
    logic [WIDTH-1:0] main_y, skid_y;
    logic             accept, deliver;
    logic             load_main, main_from_skid, load_skid;

    alu_result_mux #(.WIDTH(WIDTH)) u_mux (
        .res_and (res_and),
        .res_or  (res_or),
        .res_add (res_add),
        .res_sub (res_sub),
        .sel     (sel),
        .y       (mux_y)
    );

    // Handshake readiness comes from the registered state only, never from out_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;
    assign out_y     = main_y;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = HALF;
                    load_main = 1'b1;
                end
            end
            HALF: begin
                if (accept && !deliver) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (deliver && !accept) begin
                    state_d = EMPTY;
                end else if (accept && deliver) begin
                    load_main = 1'b1;
                end
            end
            FULL: begin
                if (deliver) begin
                    state_d        = HALF;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)              main_y <= '0;
        else if (load_main)      main_y <= mux_y;
        else if (main_from_skid) main_y <= skid_y;
    end

    // NOTE: the skid entry has no reset; state EMPTY/HALF marks it dead, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (load_skid) skid_y <= mux_y;
    end

`ifdef ALU_RESULT_FLAGS_EN
    logic main_zero, main_neg, skid_zero, skid_neg;
    logic cap_zero, cap_neg;

    assign cap_zero = (mux_y == '0);
    assign cap_neg  = mux_y[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_zero <= 1'b0;
            main_neg  <= 1'b0;
        end else if (load_main) begin
            main_zero <= cap_zero;
            main_neg  <= cap_neg;
        end else if (main_from_skid) begin
            main_zero <= skid_zero;
            main_neg  <= skid_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_zero <= cap_zero;
            skid_neg  <= cap_neg;
        end
    end

    assign out_zero = main_zero;
    assign out_neg  = main_neg;
`else
    assign out_zero = 1'b0;
    assign out_neg  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)       out_cnt <= 16'h0000;
        else if (deliver) out_cnt <= out_cnt + 16'h0001;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of all result buses.
REQ-002 The block SHALL have one clock and a synchronous active-low reset, with ports as listed below.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 res_and  input  WIDTH  result from AND unit.
REQ-006 res_or  input  WIDTH  result from OR unit (a | b).
REQ-007 res_add  input  WIDTH  result from adder.
REQ-008 res_sub  input  WIDTH  result from subtractor.
REQ-009 sel  input  2  result select: 00 AND, 01 OR, 10 ADD, 11 SUB.
REQ-010 in_valid  input  1  upstream result and sel are valid this cycle.
REQ-011 in_ready  output  1  stage can accept this cycle.
REQ-012 out_y  output  WIDTH  registered selected result.
REQ-013 out_zero  output  1  out_y == 0 (macro-gated, see REQ-030).
REQ-014 out_neg  output  1  out_y[WIDTH-1] (macro-gated, see REQ-030).
REQ-015 out_valid  output  1  out_y holds valid data.
REQ-016 out_ready  input  1  downstream consumes this cycle.
REQ-017 out_cnt  output  16  count of delivered results, wrapping.

Function
REQ-018 The block SHALL define accept = in_valid & in_ready and deliver = out_valid & out_ready.
REQ-019 On accept, the block SHALL capture the sel-chosen input into storage, giving 1 cycle latency from accept to out_valid.
REQ-020 The block SHALL use a 2-entry skid buffer (main + skid) with states EMPTY, HALF, FULL.
- EMPTY: out_valid=0, in_ready=1.
- HALF: out_valid=1, in_ready=1.
- FULL: out_valid=1, in_ready=0.
REQ-021 The state machine SHALL follow these transitions.
- EMPTY + accept -> HALF, main loaded.
- HALF + accept & !deliver -> FULL, skid loaded.
- HALF + deliver & !accept -> EMPTY.
- HALF + accept & deliver -> HALF, main reloaded.
- FULL + deliver -> HALF, main <= skid.
- All other cases hold state.
REQ-022 in_ready SHALL be a function of registered state only, with no combinational path from out_ready.
REQ-023 While out_valid=1 and out_ready=0, out_y, out_zero and out_neg SHALL hold stable.
REQ-024 Results SHALL be delivered in acceptance order, with no loss or duplication.
REQ-025 out_cnt SHALL increment by 1 on each deliver and wrap from 0xFFFF to 0x0000.
REQ-026 out_zero and out_neg SHALL be computed at capture and travel with their data entry.

Reset
REQ-027 While rst_n=0 at a rising clk edge, the block SHALL clear state to EMPTY and drive outputs as follows.
- out_valid=0, in_ready=1.
- out_y=0, out_zero=0, out_neg=0.
- out_cnt=0.
REQ-028 Reset asserted mid-operation SHALL discard main and skid contents, and no buffered result SHALL appear afterwards.
REQ-029 Inputs presented while rst_n=0 SHALL NOT be accepted.

Configuration
REQ-030 Macro ALU_RESULT_FLAGS_EN SHALL control the flag logic.
- Defined: out_zero and out_neg are generated and stored per entry as in REQ-026.
- Undefined: out_zero and out_neg are tied to 0 and no flag storage is built.

Structure
REQ-031 A shared package alu_pkg SHALL hold the sel encodings (SEL_AND, SEL_OR, SEL_ADD, SEL_SUB) and the state enum (EMPTY, HALF, FULL).
REQ-032 Sub-module alu_result_mux SHALL implement the combinational 4:1 select; buffer and counter logic stay in the top.

Verification
REQ-033 Reset release, then sel=01, res_or=0x0000_F0F0, one in_valid pulse with out_ready=1 -> next cycle out_valid=1, out_y=0x0000_F0F0, then out_cnt=1.
REQ-034 out_ready=0, accept 0x11 then 0x22 -> after the second accept in_ready=0; raise out_ready -> 0x11 then 0x22 delivered in order, then EMPTY.
REQ-035 in_valid=1 and out_ready=1 continuously, 100 results -> one delivery per cycle, in_ready never drops, out_cnt=100.
REQ-036 sel=11, res_sub=0x0000_0000 then 0x8000_0001 with ALU_RESULT_FLAGS_EN -> first result out_zero=1/out_neg=0, second out_zero=0/out_neg=1; without macro both flags always 0.
REQ-037 FULL state, assert rst_n=0 for one cycle -> out_valid=0, out_cnt=0, in_ready=1, and neither buffered value is delivered.
REQ-038 Preload out_cnt to 0xFFFF by 65535 deliveries, deliver one more -> out_cnt=0x0000.
